// File: rtl/cp0_commit_ctrl.sv
// cp0_commit_ctrl: sequencer in front of the single CP0 write port.
// Arbitrates exception commit, ERET and MTC0 from write-back, expands
// exceptions/ERET into ordered single-register writes, stalls write-back
// while busy and finishes with a one-cycle flush carrying the redirect PC.
module cp0_commit_ctrl #(
    parameter logic [31:0] EX_VECTOR   = 32'hBFC00380,
    parameter logic [4:0]  ADDR_BADV   = 5'd8,
    parameter logic [4:0]  ADDR_STATUS = 5'd12,
    parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
    parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_req,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic [4:0]  ex_code,
    input  logic [31:0] ex_badvaddr,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [31:0] status_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    output logic        req_ready,
    output logic        cp0_wen,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        flush,
    output logic [31:0] flush_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MTC0,
        S_W_EPC,
        S_W_CAUSE,
        S_W_BADV,
        S_W_STAT,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    // Copies of the request taken at acceptance; the sequence never looks
    // at the live inputs again, so write-back may change them freely.
    logic        is_ex_q,     is_ex_d;
    logic [31:0] pc_q,        pc_d;
    logic        bd_q,        bd_d;
    logic [4:0]  code_q,      code_d;
    logic [31:0] badv_q,      badv_d;
    logic [31:0] status_q,    status_d;
    logic [31:0] cause_q,     cause_d;
    logic [31:0] epc_q,       epc_d;
    logic [4:0]  maddr_q,     maddr_d;
    logic [31:0] mdata_q,     mdata_d;

    logic accept;
    logic addr_err;

    assign accept   = (state_q == S_IDLE) && (ex_req || eret_req || mtc0_req);
    assign addr_err = (code_q == 5'd4) || (code_q == 5'd5);

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, reloaded only when a request is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_ex_q  <= 1'b0;
            pc_q     <= 32'd0;
            bd_q     <= 1'b0;
            code_q   <= 5'd0;
            badv_q   <= 32'd0;
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            maddr_q  <= 5'd0;
            mdata_q  <= 32'd0;
        end else begin
            is_ex_q  <= is_ex_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            badv_q   <= badv_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
        end
    end

    // Field capture: everything is snapshotted together on acceptance.
    always_comb begin
        is_ex_d  = is_ex_q;
        pc_d     = pc_q;
        bd_d     = bd_q;
        code_d   = code_q;
        badv_d   = badv_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        if (accept) begin
            is_ex_d  = ex_req;
            pc_d     = ex_pc;
            bd_d     = ex_bd;
            code_d   = ex_code;
            badv_d   = ex_badvaddr;
            status_d = status_in;
            cause_d  = cause_in;
            epc_d    = epc_in;
            maddr_d  = mtc0_addr;
            mdata_d  = mtc0_wdata;
        end
    end

    // Next-state: fixed priority ex > eret > mtc0 in IDLE, then walk the writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ex_req) begin
                    state_d = status_in[1] ? S_W_CAUSE : S_W_EPC;
                end else if (eret_req) begin
                    state_d = S_W_STAT;
                end else if (mtc0_req) begin
                    state_d = S_MTC0;
                end
            end
            S_MTC0:    state_d = S_IDLE;
            S_W_EPC:   state_d = S_W_CAUSE;
            S_W_CAUSE: state_d = addr_err ? S_W_BADV : S_W_STAT;
            S_W_BADV:  state_d = S_W_STAT;
            S_W_STAT:  state_d = S_FLUSH;
            S_FLUSH:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from state and the latched fields.
    always_comb begin
        req_ready = 1'b0;
        cp0_wen   = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wdata = 32'd0;
        flush     = 1'b0;
        flush_pc  = 32'd0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_MTC0: begin
                cp0_wen   = 1'b1;
                cp0_waddr = maddr_q;
                cp0_wdata = mdata_q;
            end
            S_W_EPC: begin
                cp0_wen   = 1'b1;
                cp0_waddr = ADDR_EPC;
                cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
            end
            S_W_CAUSE: begin
                cp0_wen   = 1'b1;
                cp0_waddr = ADDR_CAUSE;
                cp0_wdata = {bd_q, cause_q[30:7], code_q, cause_q[1:0]};
            end
            S_W_BADV: begin
                cp0_wen   = 1'b1;
                cp0_waddr = ADDR_BADV;
                cp0_wdata = badv_q;
            end
            S_W_STAT: begin
                cp0_wen   = 1'b1;
                cp0_waddr = ADDR_STATUS;
                cp0_wdata = is_ex_q ? (status_q | 32'h2) : (status_q & ~32'h2);
            end
            S_FLUSH: begin
                flush    = 1'b1;
                flush_pc = is_ex_q ? EX_VECTOR : epc_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_commit_ctrl.sv
// tb_cp0_commit_ctrl: directed table vectors, hand-written reset and
// back-to-back sequences, and random requests checked cycle by cycle
// against an expected-output queue built from the CP0 write rules.
module tb_cp0_commit_ctrl;

    localparam logic [31:0] EX_VECTOR = 32'hBFC00380;

    typedef struct packed {
        logic        ex;
        logic        eret;
        logic        mtc0;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  code;
        logic [31:0] badv;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [4:0]  maddr;
        logic [31:0] mdata;
    } req_t;

    typedef struct packed {
        logic        ready;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        flush;
        logic [31:0] fpc;
    } out_t;

    typedef struct {
        req_t             req;
        int               nw;
        logic [4:0][4:0]  wa;
        logic [4:0][31:0] wd;
        logic [31:0]      fpc;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        ex_req;
    logic [31:0] ex_pc;
    logic        ex_bd;
    logic [4:0]  ex_code;
    logic [31:0] ex_badvaddr;
    logic        eret_req;
    logic        mtc0_req;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] status_in;
    logic [31:0] cause_in;
    logic [31:0] epc_in;
    logic        req_ready;
    logic        cp0_wen;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic [31:0] flush_pc;

    int   testCount;
    int   failCount;
    out_t expQ[$];
    vec_t vecs[5];

    cp0_commit_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_req      (ex_req),
        .ex_pc       (ex_pc),
        .ex_bd       (ex_bd),
        .ex_code     (ex_code),
        .ex_badvaddr (ex_badvaddr),
        .eret_req    (eret_req),
        .mtc0_req    (mtc0_req),
        .mtc0_addr   (mtc0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .status_in   (status_in),
        .cause_in    (cause_in),
        .epc_in      (epc_in),
        .req_ready   (req_ready),
        .cp0_wen     (cp0_wen),
        .cp0_waddr   (cp0_waddr),
        .cp0_wdata   (cp0_wdata),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t idleOut();
        out_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic void pushWrite(input logic [4:0] a, input logic [31:0] d);
        out_t o;
        o = '0;
        o.wen   = 1'b1;
        o.waddr = a;
        o.wdata = d;
        expQ.push_back(o);
    endfunction

    function automatic void pushFlush(input logic [31:0] pc);
        out_t o;
        o = '0;
        o.flush = 1'b1;
        o.fpc   = pc;
        expQ.push_back(o);
    endfunction

    // Reference: the list of register writes a request must produce.
    function automatic void modelAccept(input req_t r);
        logic [31:0] causeVal;
        if (r.ex) begin
            if (r.status[1] == 1'b0)
                pushWrite(5'd14, r.bd ? r.pc - 32'd4 : r.pc);
            causeVal = (r.cause & 32'h7FFFFF83) | (32'(r.bd) << 31) | (32'(r.code) << 2);
            pushWrite(5'd13, causeVal);
            if (r.code == 5'd4 || r.code == 5'd5)
                pushWrite(5'd8, r.badv);
            pushWrite(5'd12, r.status | 32'h2);
            pushFlush(EX_VECTOR);
        end else if (r.eret) begin
            pushWrite(5'd12, r.status & ~32'h2);
            pushFlush(r.epc);
        end else if (r.mtc0) begin
            pushWrite(r.maddr, r.mdata);
        end
    endfunction

    task automatic checkOutput(input out_t e, input string name);
        out_t a;
        a.ready = req_ready;
        a.wen   = cp0_wen;
        a.waddr = cp0_waddr;
        a.wdata = cp0_wdata;
        a.flush = flush;
        a.fpc   = flush_pc;
        testCount++;
        if (a !== e) begin
            failCount++;
            $display("[TB] FAIL %s @%0t: got ready=%b wen=%b waddr=%0d wdata=%h flush=%b fpc=%h, want ready=%b wen=%b waddr=%0d wdata=%h flush=%b fpc=%h",
                     name, $time, a.ready, a.wen, a.waddr, a.wdata, a.flush, a.fpc,
                     e.ready, e.wen, e.waddr, e.wdata, e.flush, e.fpc);
        end
    endtask

    task automatic driveReq(input req_t r);
        ex_req      = r.ex;
        eret_req    = r.eret;
        mtc0_req    = r.mtc0;
        ex_pc       = r.pc;
        ex_bd       = r.bd;
        ex_code     = r.code;
        ex_badvaddr = r.badv;
        status_in   = r.status;
        cause_in    = r.cause;
        epc_in      = r.epc;
        mtc0_addr   = r.maddr;
        mtc0_wdata  = r.mdata;
    endtask

    // One cycle: check this cycle's outputs, then drive the next request.
    task automatic applyStimulus(input req_t r, input bit doModel, input string name);
        out_t e;
        bit   wasIdle;
        @(negedge clk);
        wasIdle = (expQ.size() == 0);
        e = wasIdle ? idleOut() : expQ.pop_front();
        checkOutput(e, name);
        driveReq(r);
        if (wasIdle && doModel)
            modelAccept(r);
    endtask

    task automatic drain(input string name);
        req_t z;
        z = '0;
        for (int k = 0; k < 20 && expQ.size() != 0; k++)
            applyStimulus(z, 1'b1, name);
        applyStimulus(z, 1'b1, name);
    endtask

    initial begin
        req_t z;
        req_t r;
        vec_t v;
        testCount = 0;
        failCount = 0;
        z = '0;
        driveReq(z);
        resetn = 1'b0;

        // Vector table from the plan; expected writes computed by hand.
        v = '{req: '0, nw: 0, wa: '0, wd: '0, fpc: '0};
        v.req.ex = 1'b1; v.req.pc = 32'hBFC00100; v.req.code = 5'd8;
        v.nw = 3;
        v.wa[0] = 5'd14; v.wd[0] = 32'hBFC00100;
        v.wa[1] = 5'd13; v.wd[1] = 32'h00000020;
        v.wa[2] = 5'd12; v.wd[2] = 32'h00000002;
        v.fpc = EX_VECTOR;
        vecs[0] = v;

        v = '{req: '0, nw: 0, wa: '0, wd: '0, fpc: '0};
        v.req.ex = 1'b1; v.req.bd = 1'b1; v.req.pc = 32'h00001004;
        v.req.code = 5'd4; v.req.badv = 32'h00001233;
        v.nw = 4;
        v.wa[0] = 5'd14; v.wd[0] = 32'h00001000;
        v.wa[1] = 5'd13; v.wd[1] = 32'h80000010;
        v.wa[2] = 5'd8;  v.wd[2] = 32'h00001233;
        v.wa[3] = 5'd12; v.wd[3] = 32'h00000002;
        v.fpc = EX_VECTOR;
        vecs[1] = v;

        v = '{req: '0, nw: 0, wa: '0, wd: '0, fpc: '0};
        v.req.ex = 1'b1; v.req.pc = 32'h00002000; v.req.code = 5'd8;
        v.req.status = 32'h3;
        v.nw = 2;
        v.wa[0] = 5'd13; v.wd[0] = 32'h00000020;
        v.wa[1] = 5'd12; v.wd[1] = 32'h00000003;
        v.fpc = EX_VECTOR;
        vecs[2] = v;

        v = '{req: '0, nw: 0, wa: '0, wd: '0, fpc: '0};
        v.req.eret = 1'b1; v.req.status = 32'h3; v.req.epc = 32'h80000040;
        v.nw = 1;
        v.wa[0] = 5'd12; v.wd[0] = 32'h00000001;
        v.fpc = 32'h80000040;
        vecs[3] = v;

        v = '{req: '0, nw: 0, wa: '0, wd: '0, fpc: '0};
        v.req.ex = 1'b1; v.req.eret = 1'b1; v.req.mtc0 = 1'b1;
        v.req.pc = 32'h00003000; v.req.code = 5'd10; v.req.cause = 32'h0000FF00;
        v.req.epc = 32'h12345678; v.req.maddr = 5'd12; v.req.mdata = 32'h5;
        v.nw = 3;
        v.wa[0] = 5'd14; v.wd[0] = 32'h00003000;
        v.wa[1] = 5'd13; v.wd[1] = 32'h0000FF28;
        v.wa[2] = 5'd12; v.wd[2] = 32'h00000002;
        v.fpc = EX_VECTOR;
        vecs[4] = v;

        #2;
        checkOutput(idleOut(), "reset_state");
        @(negedge clk);
        checkOutput(idleOut(), "reset_held");
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].req, 1'b0, $sformatf("vec%0d_accept", i));
            for (int w = 0; w < vecs[i].nw; w++)
                pushWrite(vecs[i].wa[w], vecs[i].wd[w]);
            pushFlush(vecs[i].fpc);
            if (i == 4) begin
                // Only the MTC0 stays asserted; it must wait out the flush.
                r = '0;
                r.mtc0 = 1'b1; r.maddr = 5'd12; r.mdata = 32'h5;
                for (int k = 0; k < 6; k++)
                    applyStimulus(r, 1'b1, "held_mtc0");
                applyStimulus(z, 1'b1, "held_mtc0_drop");
            end
            drain($sformatf("vec%0d_seq", i));
        end

        // Reset in the middle of W_CAUSE abandons the sequence.
        r = vecs[0].req;
        applyStimulus(r, 1'b1, "rst_accept");
        applyStimulus(z, 1'b1, "rst_w_epc");
        applyStimulus(z, 1'b1, "rst_w_cause");
        resetn = 1'b0;
        #1;
        checkOutput(idleOut(), "rst_mid_immediate");
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput(idleOut(), "rst_mid_held");
        resetn = 1'b1;
        applyStimulus(z, 1'b1, "rst_no_flush0");
        applyStimulus(z, 1'b1, "rst_no_flush1");
        applyStimulus(r, 1'b1, "rst_restart");
        drain("rst_restart_seq");

        // Random requests against the reference queue.
        for (int n = 0; n < 600; n++) begin
            r = '0;
            r.ex     = ($urandom_range(0, 3) == 0);
            r.eret   = ($urandom_range(0, 3) == 0);
            r.mtc0   = ($urandom_range(0, 2) == 0);
            r.pc     = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            r.bd     = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       r.code = 5'd4;
                1:       r.code = 5'd5;
                2:       r.code = 5'd8;
                default: r.code = 5'($urandom);
            endcase
            r.badv   = $urandom;
            r.status = $urandom;
            r.cause  = $urandom;
            r.epc    = $urandom;
            r.maddr  = 5'($urandom);
            r.mdata  = $urandom;
            applyStimulus(r, 1'b1, "random");
        end
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
